// File: rtl/pdp8_binloader.sv
// BIN-format paper-tape loader. Bytes from the UART receiver are assembled into
// 12-bit words and written to RAM one frame late, so that the final frame
// (the checksum) is never written. The CPU is held in reset while loading.
`timescale 1ns/1ps
module pdp8_binloader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [14:0] ram_addr,
  output logic [11:0] ram_data_out,
  output logic        ram_wr,
  input  logic        ram_done,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        cksum_err,
  output logic        overrun
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEADER = 3'd1;
  localparam logic [2:0] S_HI     = 3'd2;
  localparam logic [2:0] S_LO     = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]  r_state;
  logic [11:0] r_addr;
  logic [2:0]  r_field;
  logic [11:0] r_sum;
  logic [7:0]  r_hi;          // first byte of the frame being assembled
  logic        r_pend_valid;
  logic [14:0] r_pend_addr;
  logic [11:0] r_pend_data;
  logic [11:0] r_pend_sum;    // both frame bytes of the pending word, added on commit
  logic [14:0] r_wr_addr;
  logic [11:0] r_wr_data;
  logic [11:0] r_wr_sum;
  logic        r_hold_valid;
  logic [7:0]  r_hold_data;
  logic        r_done;
  logic        r_cksum_err;
  logic        r_overrun;

  logic        w_loading;
  logic        w_have_byte;
  logic [7:0]  w_byte;
  logic        w_is_rubout;
  logic        w_is_leader;
  logic        w_is_field;
  logic        w_is_frame;
  logic [11:0] w_word;
  logic [11:0] w_pair_sum;

  // A held byte (captured during a RAM write) takes priority over a new one.
  assign w_loading   = (r_state == S_LEADER) || (r_state == S_HI) || (r_state == S_LO);
  assign w_have_byte = w_loading && (r_hold_valid || rx_valid);
  assign w_byte      = r_hold_valid ? r_hold_data : rx_data;
  assign w_is_rubout = (w_byte == 8'hFF);
  assign w_is_leader = (w_byte == 8'h80);
  assign w_is_field  = (w_byte[7:6] == 2'b11) && !w_is_rubout;
  assign w_is_frame  = !w_byte[7];
  assign w_word      = {r_hi[5:0], w_byte[5:0]};
  assign w_pair_sum  = {4'd0, r_hi} + {4'd0, w_byte};

  assign ram_wr       = (r_state == S_WRITE);
  assign ram_addr     = r_wr_addr;
  assign ram_data_out = r_wr_data;
  assign busy         = w_loading || (r_state == S_WRITE);
  assign cpu_hold     = busy;
  assign done         = r_done;
  assign cksum_err    = r_cksum_err;
  assign overrun      = r_overrun;

  // Loader state machine: byte decode, frame assembly, deferred commit and trailer check.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_field      <= '0;
      r_sum        <= '0;
      r_hi         <= '0;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
      r_pend_sum   <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_sum     <= '0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_done       <= 1'b0;
      r_cksum_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_addr       <= '0;
            r_field      <= '0;
            r_sum        <= '0;
            r_pend_valid <= 1'b0;
            r_hold_valid <= 1'b0;
            r_done       <= 1'b0;
            r_cksum_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_state      <= S_LEADER;
          end
        end
        S_WRITE: begin
          // The interrupted frame action was already applied when the write began,
          // so completion only folds the written word's bytes into the sum.
          if (ram_done) begin
            r_sum   <= r_sum + r_wr_sum;
            r_state <= S_HI;
          end
          if (rx_valid) begin
            if (r_hold_valid) begin
              r_overrun <= 1'b1;
            end else begin
              r_hold_valid <= 1'b1;
              r_hold_data  <= rx_data;
            end
          end
        end
        default: begin
          // Held byte is consumed now; a byte arriving meanwhile is parked behind it.
          if (r_hold_valid) begin
            r_hold_valid <= rx_valid;
            r_hold_data  <= rx_data;
          end
          if (w_have_byte && !w_is_rubout) begin
            if (w_is_leader) begin
              if (r_state == S_HI) begin
                // Trailer: the still-pending word is the checksum and is never written.
                r_cksum_err  <= !r_pend_valid || (r_pend_data != r_sum);
                r_pend_valid <= 1'b0;
                r_done       <= 1'b1;
                r_state      <= S_DONE;
              end
            end else if (w_is_field) begin
              if (r_state != S_LO) begin
                r_field <= w_byte[5:3];
                r_state <= S_HI;
              end
            end else if (w_is_frame) begin
              if (r_state != S_LO) begin
                r_hi    <= w_byte;
                r_state <= S_LO;
              end else begin
                if (r_pend_valid) begin
                  r_wr_addr <= r_pend_addr;
                  r_wr_data <= r_pend_data;
                  r_wr_sum  <= r_pend_sum;
                  r_state   <= S_WRITE;
                end else begin
                  r_state <= S_HI;
                end
                if (r_hi[6]) begin
                  r_addr       <= w_word;
                  r_sum        <= r_sum + w_pair_sum;
                  r_pend_valid <= 1'b0;
                end else begin
                  r_pend_addr  <= {r_field, r_addr};
                  r_pend_data  <= w_word;
                  r_pend_sum   <= w_pair_sum;
                  r_pend_valid <= 1'b1;
                  r_addr       <= r_addr + 12'd1;
                end
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/pdp8_binloader.md
PDP8_BINLOADER -- requirements
Module: pdp8_binloader

Purpose: BIN-format paper-tape loader. Takes bytes from the UART receiver, writes 12-bit words into the pdp8_ram port, and holds the CPU in reset until the load completes.

Interface
REQ-001 clk  in  1  system clock; all logic on posedge.
REQ-002 reset  in  1  synchronous reset, active-high.
REQ-003 start  in  1  one-cycle pulse; begins a load.
REQ-004 rx_data  in  8  received byte; valid only when rx_valid=1.
REQ-005 rx_valid  in  1  one-cycle strobe per received byte.
REQ-006 ram_addr  out  15  write address {field[2:0], addr[11:0]}.
REQ-007 ram_data_out  out  12  write data.
REQ-008 ram_wr  out  1  write request; held until ram_done.
REQ-009 ram_done  in  1  write complete; sampled while ram_wr=1.
REQ-010 cpu_hold  out  1  1 = keep CPU in reset.
REQ-011 busy  out  1  1 = load in progress.
REQ-012 done  out  1  sticky; 1 = load finished.
REQ-013 cksum_err  out  1  sticky; 1 = checksum mismatch or missing checksum.
REQ-014 overrun  out  1  sticky; 1 = a byte was dropped.

Function
REQ-015 States SHALL be IDLE, LEADER, HI, LO, WRITE and DONE.
REQ-016 start in IDLE or DONE SHALL:
- clear addr, field, sum, pending_valid, done, cksum_err and overrun;
- enter LEADER.
REQ-017 start in any other state SHALL be ignored.
REQ-018 busy and cpu_hold SHALL be 1 exactly in LEADER, HI, LO and WRITE.
REQ-019 Byte classes, decoded on rx_data:
- 0200 = leader/trailer;
- 0377 = rubout, always discarded with no effect;
- 03xx other than 0377 = field setting, field <= bits[5:3];
- bit7=0 = frame byte; bit6=1 on a first byte marks an origin frame.
REQ-020 LEADER: leader bytes SHALL be discarded. Any other byte SHALL be processed as in HI.
REQ-021 HI:
- frame byte: hold it as the first byte and go to LO;
- field byte: update field and stay in HI;
- leader byte: trailer detected (REQ-028).
REQ-022 LO: a frame byte SHALL complete the frame, word = {hi[5:0], lo[5:0]}. Leader and field bytes in LO SHALL be discarded and the state SHALL stay LO.
REQ-023 Origin frame completion SHALL:
- first commit any pending word (REQ-025);
- then set addr <= word;
- add both frame bytes (8-bit values) to sum;
- return to HI.
REQ-024 Data frame completion SHALL:
- commit any pending word (REQ-025);
- then load pending <= {field, addr, word} and set pending_valid=1;
- set addr <= addr+1, 12-bit wrap, field unchanged;
- hold the frame bytes with the pending word, not yet in sum;
- return to HI.
REQ-025 Commit SHALL:
- enter WRITE with ram_addr/ram_data_out taken from the pending word, ram_wr=1;
- on the cycle ram_done=1, drop ram_wr on the next cycle and add the pending word's two bytes to sum;
- then continue the interrupted action.
REQ-026 ram_addr and ram_data_out SHALL stay stable while ram_wr=1. ram_wr SHALL be 1 only in WRITE.
REQ-027 sum SHALL be 12 bits and wrap modulo 4096. Field, leader and rubout bytes SHALL never enter sum.
REQ-028 Trailer SHALL:
- if pending_valid, compare the pending word to sum and set cksum_err=1 on mismatch;
- if no pending word, set cksum_err=1;
- never write the pending (checksum) word;
- set done=1 and enter DONE.
REQ-029 A byte arriving in WRITE SHALL go into a one-entry holding register and be processed on the first cycle after WRITE.
REQ-030 A byte arriving while the holding register is full SHALL be dropped and set overrun=1.
REQ-031 rx_valid in IDLE or DONE SHALL be ignored.
REQ-032 Every byte SHALL be processed in one cycle outside WRITE. No byte SHALL be lost when bytes are at least 2 cycles apart.

Reset
REQ-033 reset=1 SHALL, on the next edge, from any state including mid-write:
- go to IDLE;
- drive every output to 0, including ram_wr and cpu_hold;
- clear addr, field, sum, pending_valid and the holding register.

Verification
- V1: reset for 3 cycles -> all outputs 0, state IDLE; rx_valid bytes ignored.
- V2: start; then 0200,0200,0101,0000,0012,0034,0001,0047,0200, with ram_done returned 1 cycle after ram_wr -> exactly one write, addr 00100 data 1234; done=1, cksum_err=0, cpu_hold=0.
- V3: V2 with checksum bytes 0001,0050 -> same single write; done=1, cksum_err=1.
- V4: V2 with 0310 sent before the origin -> write at 10100; checksum 0147 still passes.
- V5: origin 7777 (bytes 0177,0077); data 0000,0001 then 0000,0002; correct checksum; trailer -> writes 07777=0001 and 00000=0002.
- V6: ram_done delayed 4 cycles, and 2 bytes arriving during WRITE -> ram_wr held 4 cycles with stable addr/data; first byte processed after WRITE; second byte sets overrun=1.
- V7: reset pulsed while ram_wr=1 -> next cycle ram_wr=0, busy=0, cpu_hold=0, done=0.
